// File: rtl/mem_rd_arbiter.sv
// -----------------------------------------------------------------------------
// mem_rd_arbiter
//
// Purpose:
//   Shares one read port of the input RAM between two burst requesters (for
//   example the A-row and B-column fetch engines). Requests are arbitrated
//   round-robin. The granted burst is issued as one address per cycle, and
//   returned words are routed back to the requester that owns them.
//
// Ports:
//   i_clk            clock, rising edge
//   i_rst            asynchronous active-high reset
//   i_req0/1         burst request, held until the matching grant pulse
//   i_addr0/1        burst start word address, stable while request is high
//   i_len0/1         burst length in words, 0 encodes 2^LEN_WIDTH
//   o_gnt0/1         one-cycle grant pulse
//   o_rvalid0/1      read data valid for that requester
//   o_rdata0/1       read data, forced to zero when not valid
//   o_mem_addr       read address to the RAM
//   o_mem_read_enb   read enable to the RAM
//   i_mem_data       RAM read data, valid RD_LATENCY cycles after sampling
//   o_busy           burst issuing or read data still in flight
//
// RD_LATENCY is meant to be in the range 1..4.
// -----------------------------------------------------------------------------
module mem_rd_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 64,
  parameter int RD_LATENCY = 1,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req0,
  input  logic [ADDR_WIDTH-1:0] i_addr0,
  input  logic [LEN_WIDTH-1:0]  i_len0,
  output logic                  o_gnt0,
  output logic                  o_rvalid0,
  output logic [DATA_WIDTH-1:0] o_rdata0,
  input  logic                  i_req1,
  input  logic [ADDR_WIDTH-1:0] i_addr1,
  input  logic [LEN_WIDTH-1:0]  i_len1,
  output logic                  o_gnt1,
  output logic                  o_rvalid1,
  output logic [DATA_WIDTH-1:0] o_rdata1,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_read_enb,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  output logic                  o_busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_stateNext;

  logic                  w_grant;
  logic                  w_grantPort;
  logic                  w_step;
  logic                  w_finish;
  logic [ADDR_WIDTH-1:0] w_grantAddr;
  logic [LEN_WIDTH-1:0]  w_grantLen;

  logic                  r_gnt0;
  logic                  r_gnt1;
  logic [ADDR_WIDTH-1:0] r_memAddr;
  logic                  r_memReadEnb;
  logic [LEN_WIDTH-1:0]  r_remaining;
  logic                  r_port;
  logic                  r_favour;
  logic [RD_LATENCY-1:0] r_tagValid;
  logic [RD_LATENCY-1:0] r_tagPort;

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state and control decode. When both ports request, r_favour picks
  // the one that was not served last; a lone request is granted directly.
  always_comb begin
    w_stateNext = r_state;
    w_grant     = 1'b0;
    w_grantPort = 1'b0;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_req0 | i_req1) begin
          w_grant     = 1'b1;
          w_grantPort = (i_req0 & i_req1) ? r_favour : i_req1;
          w_stateNext = BURST;
        end
      end
      BURST: begin
        if (r_remaining != '0) begin
          w_step = 1'b1;
        end else begin
          w_finish    = 1'b1;
          w_stateNext = IDLE;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  assign w_grantAddr = w_grantPort ? i_addr1 : i_addr0;
  assign w_grantLen  = w_grantPort ? i_len1  : i_len0;

  // Burst issue datapath. The grant edge already presents the first address,
  // so remaining counts the beats still to come; len=0 wraps to all ones,
  // giving the full 2^LEN_WIDTH burst. Address increments wrap naturally.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_gnt0       <= 1'b0;
      r_gnt1       <= 1'b0;
      r_memAddr    <= '0;
      r_memReadEnb <= 1'b0;
      r_remaining  <= '0;
      r_port       <= 1'b0;
      r_favour     <= 1'b0;
    end else begin
      r_gnt0 <= w_grant & ~w_grantPort;
      r_gnt1 <= w_grant & w_grantPort;
      if (w_grant) begin
        r_memAddr    <= w_grantAddr;
        r_remaining  <= w_grantLen - LEN_WIDTH'(1);
        r_memReadEnb <= 1'b1;
        r_port       <= w_grantPort;
        r_favour     <= ~w_grantPort;
      end else if (w_step) begin
        r_memAddr   <= r_memAddr + ADDR_WIDTH'(1);
        r_remaining <= r_remaining - LEN_WIDTH'(1);
      end else if (w_finish) begin
        r_memReadEnb <= 1'b0;
      end
    end
  end

  // Return tag pipeline. Each issued beat carries its owner alongside the RAM
  // access, so data from a finishing burst still lands on the right port
  // after the next grant has started issuing.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tagValid <= '0;
      r_tagPort  <= '0;
    end else begin
      r_tagValid[0] <= r_memReadEnb;
      r_tagPort[0]  <= r_port;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_tagValid[i] <= r_tagValid[i-1];
        r_tagPort[i]  <= r_tagPort[i-1];
      end
    end
  end

  assign o_gnt0         = r_gnt0;
  assign o_gnt1         = r_gnt1;
  assign o_mem_addr     = r_memAddr;
  assign o_mem_read_enb = r_memReadEnb;

  assign o_rvalid0 = r_tagValid[RD_LATENCY-1] & ~r_tagPort[RD_LATENCY-1];
  assign o_rvalid1 = r_tagValid[RD_LATENCY-1] &  r_tagPort[RD_LATENCY-1];
  assign o_rdata0  = o_rvalid0 ? i_mem_data : '0;
  assign o_rdata1  = o_rvalid1 ? i_mem_data : '0;

  assign o_busy = (r_state != IDLE) | (|r_tagValid);

endmodule
